// File: rtl/mod_transmitter_if.sv
// Byte-stream and sample bus between the framing source, the modulating transmitter and the DAC side.
interface mod_transmitter_if #(
    parameter int unsigned BYTE_WIDTH   = 8,
    parameter int unsigned OUTPUT_WIDTH = 12,
    parameter int unsigned FCW_WIDTH    = 16
);
    logic [BYTE_WIDTH-1:0]   data_in;
    logic                    data_valid;
    logic                    data_ready;
    logic [1:0]              mode;
    logic [FCW_WIDTH-1:0]    fcw0;
    logic [FCW_WIDTH-1:0]    fcw1;
    logic [OUTPUT_WIDTH-1:0] sine_c;
    logic [OUTPUT_WIDTH-1:0] mod_out;
    logic                    bit_strobe;
    logic                    busy;

    modport master (
        output data_in, data_valid, mode, fcw0, fcw1,
        input  data_ready, sine_c, mod_out, bit_strobe, busy
    );

    modport slave (
        input  data_in, data_valid, mode, fcw0, fcw1,
        output data_ready, sine_c, mod_out, bit_strobe, busy
    );
endinterface

// File: rtl/mod_transmitter.sv
// Byte-buffered MSB-first serializer driving an ASK/FSK/BPSK/carrier modulator from an internal nco.
// Optional PRBS7 bit scrambling is enabled by defining MOD_TX_SCRAMBLE_EN.
module mod_transmitter #(
    parameter int unsigned OUTPUT_WIDTH    = 12,
    parameter int unsigned FCW_WIDTH       = 16,
    parameter int unsigned BYTE_WIDTH      = 8,
    parameter int unsigned SAMPLES_PER_SYM = 16
) (
    input logic              clk,
    input logic              rst,
    mod_transmitter_if.slave bus
);
    localparam int unsigned SYM_W = (SAMPLES_PER_SYM > 1) ? $clog2(SAMPLES_PER_SYM) : 1;
    localparam int unsigned BIT_W = (BYTE_WIDTH > 1) ? $clog2(BYTE_WIDTH) : 1;
    localparam int unsigned TRI_W = OUTPUT_WIDTH + 1;
    localparam logic [SYM_W-1:0] SYM_LAST = SYM_W'(SAMPLES_PER_SYM - 1);
    localparam logic [BIT_W-1:0] BIT_LAST = BIT_W'(BYTE_WIDTH - 1);
    localparam logic [OUTPUT_WIDTH-1:0] MIDSCALE = {1'b1, {(OUTPUT_WIDTH-1){1'b0}}};
    localparam logic [TRI_W-1:0] QUARTER = {2'b01, {(OUTPUT_WIDTH-1){1'b0}}};

    typedef enum logic {IDLE, SEND} state_t;
    typedef enum logic [1:0] {MODE_ASK, MODE_FSK, MODE_BPSK, MODE_CARRIER} mode_t;

    state_t                  state, state_n;
    mode_t                   mode_q, mode_n;
    logic [BYTE_WIDTH-1:0]   shreg, shreg_n, buf_data, buf_data_n;
    logic                    buf_full, buf_full_n;
    logic [SYM_W-1:0]        sym_cnt, sym_cnt_n;
    logic [BIT_W-1:0]        bit_cnt, bit_cnt_n;
    logic                    ready_q, strobe_q, strobe_n;
    logic [OUTPUT_WIDTH-1:0] mod_q, mod_n;
    logic [FCW_WIDTH-1:0]    phase, fcw_sel;
    logic [TRI_W-1:0]        tri_ph;
    logic [OUTPUT_WIDTH-1:0] sine_c;
    logic                    xfer, load_buf, load_in, next_bit, tx_bit;

    assign xfer = bus.data_valid & ready_q;

    // nco: phase accumulator with a triangle amplitude map, midscale at phase 0
    assign tri_ph = phase[FCW_WIDTH-1 -: TRI_W] + QUARTER;
    assign sine_c = tri_ph[TRI_W-1] ? ~tri_ph[OUTPUT_WIDTH-1:0] : tri_ph[OUTPUT_WIDTH-1:0];

    // Next-state: buffer, serializer counters and seamless byte reload
    always_comb begin
        state_n    = state;
        shreg_n    = shreg;
        sym_cnt_n  = sym_cnt;
        bit_cnt_n  = bit_cnt;
        mode_n     = mode_q;
        buf_data_n = buf_data;
        buf_full_n = buf_full;
        strobe_n   = 1'b0;
        load_buf   = 1'b0;
        load_in    = 1'b0;
        next_bit   = 1'b0;
        case (state)
            IDLE: begin
                if (buf_full) begin
                    load_buf = 1'b1;
                    state_n  = SEND;
                end
            end
            SEND: begin
                if (sym_cnt != SYM_LAST) begin
                    sym_cnt_n = sym_cnt + SYM_W'(1);
                end else if (bit_cnt != BIT_LAST) begin
                    sym_cnt_n = '0;
                    bit_cnt_n = bit_cnt + BIT_W'(1);
                    shreg_n   = shreg << 1;
                    strobe_n  = 1'b1;
                    next_bit  = 1'b1;
                end else if (buf_full) begin
                    load_buf = 1'b1;
                end else if (xfer) begin
                    load_in = 1'b1;
                end else begin
                    state_n = IDLE;
                end
            end
            default: state_n = IDLE;
        endcase
        if (load_buf | load_in) begin
            shreg_n   = load_buf ? buf_data : bus.data_in;
            mode_n    = mode_t'(bus.mode);
            sym_cnt_n = '0;
            bit_cnt_n = '0;
            strobe_n  = 1'b1;
        end
        if (load_buf) buf_full_n = 1'b0;
        // a byte taken straight into the shift register bypasses the buffer
        if (xfer & ~load_in) begin
            buf_full_n = 1'b1;
            buf_data_n = bus.data_in;
        end
    end

`ifdef MOD_TX_SCRAMBLE_EN
    logic [6:0] lfsr, lfsr_n;

    // PRBS7 reseeds only when a burst starts from idle
    always_comb begin
        lfsr_n = lfsr;
        if (state == IDLE && load_buf) lfsr_n = 7'h7F;
        else if (next_bit | load_buf | load_in) lfsr_n = {lfsr[5:0], lfsr[6] ^ lfsr[5]};
    end

    always_ff @(posedge clk) begin
        if (!rst) lfsr <= 7'h7F;
        else      lfsr <= lfsr_n;
    end

    assign tx_bit = shreg[BYTE_WIDTH-1] ^ lfsr[6];
`else
    assign tx_bit = shreg[BYTE_WIDTH-1];
`endif

    // Modulator: carrier frequency select and next output sample
    always_comb begin
        fcw_sel = bus.fcw0;
        mod_n   = MIDSCALE;
        if (state == SEND) begin
            case (mode_q)
                MODE_ASK:  mod_n = tx_bit ? sine_c : MIDSCALE;
                MODE_BPSK: mod_n = tx_bit ? sine_c : ~sine_c;
                MODE_FSK: begin
                    mod_n = sine_c;
                    if (tx_bit) fcw_sel = bus.fcw1;
                end
                default:   mod_n = sine_c;
            endcase
        end else if (mode_t'(bus.mode) == MODE_CARRIER) begin
            mod_n = sine_c;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            state    <= IDLE;
            mode_q   <= MODE_ASK;
            shreg    <= '0;
            buf_data <= '0;
            buf_full <= 1'b0;
            sym_cnt  <= '0;
            bit_cnt  <= '0;
            ready_q  <= 1'b0;
            strobe_q <= 1'b0;
            mod_q    <= MIDSCALE;
            phase    <= '0;
        end else begin
            state    <= state_n;
            mode_q   <= mode_n;
            shreg    <= shreg_n;
            buf_data <= buf_data_n;
            buf_full <= buf_full_n;
            sym_cnt  <= sym_cnt_n;
            bit_cnt  <= bit_cnt_n;
            ready_q  <= ~buf_full_n;
            strobe_q <= strobe_n;
            mod_q    <= mod_n;
            phase    <= phase + fcw_sel;
        end
    end

    assign bus.data_ready = ready_q;
    assign bus.busy       = (state == SEND);
    assign bus.bit_strobe = strobe_q;
    assign bus.mod_out    = mod_q;
    assign bus.sine_c     = sine_c;
endmodule
